// File: rtl/pbit_pkg.sv
// rtl/pbit_pkg.sv - shared constants, types and local-field helper for the p-bit array
package pbit_pkg;

  localparam int NPBIT = 3;
  localparam int WW    = 8;
  localparam int IW    = 10;
  localparam int ISAT  = 128;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic SPIN_POS = 1'b1;
  localparam logic SPIN_NEG = 1'b0;

  localparam int ERR_MULTI = 0;
  localparam int ERR_ORDER = 1;

  localparam logic signed [IW-1:0] I_MAX = IW'(ISAT);
  localparam logic signed [IW-1:0] I_MIN = -I_MAX;

  typedef enum logic [1:0] {
    EXP_P0 = 2'd0,
    EXP_P1 = 2'd1,
    EXP_P2 = 2'd2
  } exp_e;

  function automatic logic signed [IW-1:0] sext_w(input logic [WW-1:0] v);
    return {{(IW-WW){v[WW-1]}}, v};
  endfunction

  // Couplings are packed by pair: {0,1}->slot 0, {0,2}->slot 1, {1,2}->slot 2,
  // i.e. slot = i + j - 1 for any i != j.
  function automatic logic signed [WW:0] field_sat(
    input logic [1:0]          idx,
    input logic [NPBIT-1:0]    mm,
    input logic [NPBIT*WW-1:0] jf,
    input logic [NPBIT*WW-1:0] hf
  );
    logic signed [IW-1:0] acc;
    logic signed [IW-1:0] jv;
    acc = sext_w(hf[int'(idx)*WW +: WW]);
    for (int j = 0; j < NPBIT; j++) begin
      if (j != int'(idx)) begin
        jv  = sext_w(jf[(int'(idx) + j - 1)*WW +: WW]);
        acc = (mm[j] == SPIN_POS) ? acc + jv : acc - jv;
      end
    end
    if (acc > I_MAX) acc = I_MAX;
    else if (acc < I_MIN) acc = I_MIN;
    return acc[WW:0];
  endfunction

endpackage

// File: rtl/pbit_lfsr16.sv
// rtl/pbit_lfsr16.sv - 16-bit right-shifting Galois LFSR, advances every non-reset cycle
module pbit_lfsr16
  import pbit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] state
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= SEED;
    end else if (state[0]) begin
      state <= (state >> 1) ^ LFSR_TAPS;
    end else begin
      state <= state >> 1;
    end
  end

endmodule

// File: rtl/pbit_update_array.sv
// rtl/pbit_update_array.sv - three p-bit network updated by one-hot sequencer strobes
module pbit_update_array
  import pbit_pkg::*;
#(
  parameter logic [15:0]      SEED   = 16'hACE1,
  parameter logic [NPBIT-1:0] M_INIT = 3'b000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NPBIT-1:0]    update_sequence,
  input  logic [NPBIT*WW-1:0] j_flat,
  input  logic [NPBIT*WW-1:0] h_flat,
  output logic [NPBIT-1:0]    m,
  output logic                sweep_done,
  output logic [15:0]         sweep_cnt,
  output logic [1:0]          err
);

  logic [15:0]          lfsr;
  logic                 unused_lfsr_hi;
  logic                 strobe_valid;
  logic                 strobe_multi;
  logic [1:0]           strobe_idx;
  logic signed [WW:0]   i_sat;
  logic signed [WW:0]   r_ext;
  logic                 new_bit;
  logic                 out_of_order;
  logic                 sweep_hit;
  logic [NPBIT-1:0]     m_d;
  logic [1:0]           err_d;
  exp_e                 exp_q;
  exp_e                 exp_d;

  pbit_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .CLK   (CLK),
    .RST   (RST),
    .state (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:WW];

  always_comb begin
    strobe_valid = $onehot(update_sequence);
    strobe_multi = (update_sequence != '0) && !strobe_valid;
    strobe_idx   = 2'd0;
    if (update_sequence[1]) begin
      strobe_idx = 2'd1;
    end else if (update_sequence[2]) begin
      strobe_idx = 2'd2;
    end
  end

  // Field and random draw both use this cycle's state; the write lands at the edge.
  assign i_sat     = field_sat(strobe_idx, m, j_flat, h_flat);
  assign r_ext     = {lfsr[WW-1], lfsr[WW-1:0]};
  assign new_bit   = (i_sat > r_ext);
  assign sweep_hit = strobe_valid && (strobe_idx == 2'd2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      exp_q <= EXP_P0;
    end else begin
      exp_q <= exp_d;
    end
  end

  always_comb begin
    exp_d        = exp_q;
    out_of_order = 1'b0;
    if (strobe_valid) begin
      out_of_order = (strobe_idx != 2'(exp_q));
      case (strobe_idx)
        2'd0:    exp_d = EXP_P1;
        2'd1:    exp_d = EXP_P2;
        default: exp_d = EXP_P0;
      endcase
    end
  end

  always_comb begin
    m_d   = m;
    err_d = err;
    if (strobe_valid) begin
      m_d[strobe_idx] = new_bit;
    end
    if (strobe_multi) begin
      err_d[ERR_MULTI] = 1'b1;
    end
    if (out_of_order) begin
      err_d[ERR_ORDER] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m          <= M_INIT;
      sweep_done <= 1'b0;
      sweep_cnt  <= '0;
      err        <= '0;
    end else begin
      m          <= m_d;
      err        <= err_d;
      sweep_done <= sweep_hit;
      if (sweep_hit) begin
        sweep_cnt <= sweep_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pbit_update_array.sv
// tb/tb_pbit_update_array.sv - scoreboard bench for pbit_update_array
module tb_pbit_update_array;

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [2:0]  M_INIT = 3'b101;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  update_sequence;
  logic [23:0] j_flat;
  logic [23:0] h_flat;
  logic [2:0]  m;
  logic        sweep_done;
  logic [15:0] sweep_cnt;
  logic [1:0]  err;

  pbit_update_array #(
    .SEED   (SEED),
    .M_INIT (M_INIT)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .update_sequence (update_sequence),
    .j_flat          (j_flat),
    .h_flat          (h_flat),
    .m               (m),
    .sweep_done      (sweep_done),
    .sweep_cnt       (sweep_cnt),
    .err             (err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]  fm;
    logic        fsd;
    logic [15:0] fcnt;
    logic [1:0]  ferr;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [2:0]  mdl_m;
  logic [15:0] mdl_lfsr;
  int          mdl_exp;
  logic [15:0] mdl_cnt;
  logic [1:0]  mdl_err;
  logic        mdl_sd;

  function automatic int wsigned(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int coup(input int a, input int b);
    case (a + b)
      1:       return wsigned(j_flat[7:0]);
      2:       return wsigned(j_flat[15:8]);
      default: return wsigned(j_flat[23:16]);
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic [2:0] us);
    int ones, i, fld, r;
    ones = $countones(us);
    r    = wsigned(mdl_lfsr[7:0]);
    if (rst) begin
      mdl_m    = M_INIT;
      mdl_lfsr = SEED;
      mdl_exp  = 0;
      mdl_cnt  = 16'd0;
      mdl_err  = 2'b00;
      mdl_sd   = 1'b0;
    end else begin
      mdl_sd = 1'b0;
      if (ones == 1) begin
        i   = (us == 3'b001) ? 0 : (us == 3'b010) ? 1 : 2;
        fld = wsigned(h_flat[i*8 +: 8]);
        for (int j = 0; j < 3; j++)
          if (j != i) fld += coup(i, j) * (mdl_m[j] ? 1 : -1);
        if (fld > 128) fld = 128;
        if (fld < -128) fld = -128;
        mdl_m[i] = (fld > r);
        if (i != mdl_exp) mdl_err[1] = 1'b1;
        mdl_exp = (i + 1) % 3;
        if (i == 2) begin
          mdl_sd  = 1'b1;
          mdl_cnt = mdl_cnt + 16'd1;
        end
      end else if (ones > 1) begin
        mdl_err[0] = 1'b1;
      end
      mdl_lfsr = mdl_lfsr[0] ? ((mdl_lfsr >> 1) ^ 16'hB400) : (mdl_lfsr >> 1);
    end
  endtask

  task automatic drive(input logic rst, input logic [2:0] us);
    obs_t e;
    RST             = rst;
    update_sequence = us;
    model_step(rst, us);
    e = '{fm: mdl_m, fsd: mdl_sd, fcnt: mdl_cnt, ferr: mdl_err};
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  always @(negedge CLK) begin : monitor
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{fm: m, fsd: sweep_done, fcnt: sweep_cnt, ferr: err};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual m=%b sd=%b cnt=%0d err=%b expected m=%b sd=%b cnt=%0d err=%b",
                 $time, a.fm, a.fsd, a.fcnt, a.ferr, e.fm, e.fsd, e.fcnt, e.ferr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones_cnt[3];
    int upd_cnt[3];
    int r0;

    RST = 1'b1; update_sequence = 3'b000; j_flat = '0; h_flat = '0;

    drive(1'b1, 3'b000);
    drive(1'b1, 3'b000);
    chk("reset_m", 32'(m), 32'(M_INIT));
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_cnt", 32'(sweep_cnt), 32'd0);
    chk("reset_sd", 32'(sweep_done), 32'd0);

    j_flat = '0;
    for (int k = 0; k < 100; k++) begin
      h_flat = {8'($urandom), 8'($urandom), 8'd127};
      repeat ($urandom_range(0, 5)) drive(1'b0, 3'b000);
      r0 = wsigned(mdl_lfsr[7:0]);
      drive(1'b0, 3'b001);
      chk("forced_up", 32'(m[0]), (127 > r0) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 100; k++) begin
      h_flat = {8'($urandom), 8'($urandom), 8'h80};
      repeat ($urandom_range(0, 5)) drive(1'b0, 3'b000);
      drive(1'b0, 3'b001);
      chk("forced_down", 32'(m[0]), 32'd0);
    end

    drive(1'b1, 3'b000);
    j_flat = {8'd0, 8'd127, 8'd0};
    h_flat = {8'd0, 8'd0, 8'd127};
    drive(1'b0, 3'b001);
    chk("sat_pos_m0", 32'(m[0]), 32'd1);
    j_flat = '0;
    h_flat = {8'h80, 8'h80, 8'd0};
    drive(1'b0, 3'b010);
    chk("sat_neg_m1", 32'(m[1]), 32'd0);
    drive(1'b0, 3'b100);
    chk("chain_m", 32'(m), 32'b001);
    chk("chain_sd1", 32'(sweep_done), 32'd1);
    chk("chain_cnt1", 32'(sweep_cnt), 32'd1);
    chk("chain_err", 32'(err), 32'd0);
    j_flat = {8'd127, 8'd0, 8'd127};
    h_flat = '0;
    drive(1'b0, 3'b010);
    chk("chain_sd_idle", 32'(sweep_done), 32'd0);
    drive(1'b0, 3'b100);
    chk("chain_sd2", 32'(sweep_done), 32'd1);
    chk("chain_cnt2", 32'(sweep_cnt), 32'd2);
    drive(1'b0, 3'b000);
    chk("chain_sd_drop", 32'(sweep_done), 32'd0);

    drive(1'b1, 3'b000);
    drive(1'b0, 3'b011);
    chk("multi_m", 32'(m), 32'(M_INIT));
    chk("multi_err", 32'(err), 32'b01);
    drive(1'b0, 3'b100);
    chk("order_err", 32'(err), 32'b11);
    chk("order_cnt", 32'(sweep_cnt), 32'd1);
    repeat (50) drive(1'b0, 3'b000);
    chk("err_sticky", 32'(err), 32'b11);

    for (int k = 0; k < 2000; k++) begin
      j_flat = 24'($urandom);
      h_flat = 24'($urandom);
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom));
    end

    drive(1'b1, 3'b000);
    j_flat = '0;
    h_flat = '0;
    for (int p = 0; p < 3; p++) begin
      ones_cnt[p] = 0;
      upd_cnt[p]  = 0;
    end
    for (int c = 0; c < 30000; c++) begin
      logic [2:0] us;
      case (c % 9)
        0:       us = 3'b001;
        3:       us = 3'b010;
        6:       us = 3'b100;
        default: us = 3'b000;
      endcase
      drive(1'b0, us);
      for (int p = 0; p < 3; p++) begin
        if (us[p]) begin
          upd_cnt[p]++;
          ones_cnt[p] += int'(m[p]);
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("stat_frac_p%0d ones=%0d of", p, ones_cnt[p]),
          32'(ones_cnt[p] * 100 >= upd_cnt[p] * 45 && ones_cnt[p] * 100 <= upd_cnt[p] * 55), 32'd1);
    end
    chk("stat_cnt_range", 32'(sweep_cnt == 16'd3333 || sweep_cnt == 16'd3334), 32'd1);
    chk("stat_err", 32'(err), 32'd0);

    drive(1'b1, 3'b000);
    drive(1'b0, 3'b001);
    drive(1'b1, 3'b010);
    chk("rst_mid_m", 32'(m), 32'(M_INIT));
    chk("rst_mid_cnt", 32'(sweep_cnt), 32'd0);
    drive(1'b0, 3'b001);
    chk("rst_mid_err", 32'(err), 32'd0);

    drive(1'b0, 3'b000);
    @(negedge CLK);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
